// File: rtl/sub_share_arb.sv
// -----------------------------------------------------------------------------
// sub_share_arb: round-robin arbiter sharing one 8-bit subtractor among four
// requesters. Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sub_share_arb #(
  parameter int SUB_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  req_ready,
  output logic        sub_en,
  output logic [7:0]  sub_a,
  output logic [7:0]  sub_b,
  input  logic [8:0]  sub_c,
  output logic [3:0]  rsp_valid,
  output logic [8:0]  rsp_c,
  output logic [1:0]  rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_id;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_sub_en;
  logic [3:0]  r_rsp_valid;
  logic [8:0]  r_rsp_c;
  logic [1:0]  r_rsp_id;

  logic        w_found;
  logic [1:0]  w_gnt;

  // Search starts at the pointer so the last winner goes to the back of the line.
  always_comb begin
    logic [1:0] v_idx;
    w_found = 1'b0;
    w_gnt   = 2'd0;
    v_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = v_idx;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE && w_found) ? (4'b0001 << w_gnt) : 4'b0000;
  assign busy      = (r_state != S_IDLE);
  assign sub_en    = r_sub_en;
  assign sub_a     = r_a;
  assign sub_b     = r_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_c     = r_rsp_c;
  assign rsp_id    = r_rsp_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_ptr       <= 2'd0;
      r_id        <= 2'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_sub_en    <= 1'b0;
      r_rsp_valid <= 4'd0;
      r_rsp_c     <= 9'd0;
      r_rsp_id    <= 2'd0;
    end else begin
      r_rsp_valid <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= req_a[8*w_gnt +: 8];
            r_b      <= req_b[8*w_gnt +: 8];
            r_id     <= w_gnt;
            r_ptr    <= w_gnt + 2'd1;
            r_cnt    <= 3'd0;
            r_sub_en <= 1'b1;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt + 3'd1 == 3'(SUB_LAT)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Operands are cleared on the way out so the subtractor sees zeros when idle.
          r_rsp_c     <= sub_c;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 4'b0001 << r_id;
          r_sub_en    <= 1'b0;
          r_a         <= 8'd0;
          r_b         <= 8'd0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sub_share_arb.sv
// -----------------------------------------------------------------------------
// tb_sub_share_arb: scoreboard bench for sub_share_arb with registered
// subtractor models at latency 1 and 3. Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_sub_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [31:0] req_a, req_b;
  logic        sub_en, busy;
  logic [7:0]  sub_a, sub_b;
  logic [8:0]  sub_c, rsp_c;
  logic [1:0]  rsp_id;

  logic [3:0]  req_valid3, req_ready3, rsp_valid3;
  logic [31:0] req_a3, req_b3;
  logic        sub_en3, busy3;
  logic [7:0]  sub_a3, sub_b3;
  logic [8:0]  sub_c3, rsp_c3;
  logic [1:0]  rsp_id3;

  logic [8:0]  p1, p3_0, p3_1, p3_2;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  typedef struct packed { logic [1:0] id; logic [8:0] c; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered subtractor models: result valid SUB_LAT cycles after operands appear.
  always @(posedge clk) begin
    p1   <= {1'b0, sub_a} - {1'b0, sub_b};
    p3_0 <= {1'b0, sub_a3} - {1'b0, sub_b3};
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign sub_c  = p1;
  assign sub_c3 = p3_2;

  sub_share_arb #(.SUB_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .sub_en(sub_en), .sub_a(sub_a), .sub_b(sub_b), .sub_c(sub_c),
    .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_id(rsp_id), .busy(busy)
  );

  sub_share_arb #(.SUB_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .sub_en(sub_en3), .sub_a(sub_a3), .sub_b(sub_b3), .sub_c(sub_c3),
    .rsp_valid(rsp_valid3), .rsp_c(rsp_c3), .rsp_id(rsp_id3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid !== 4'b0000) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_onehot", 32'(rsp_valid), 32'(4'b0001 << e.id));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_c", 32'(rsp_c), 32'(e.c));
      end
    end
  end

  task automatic wait_grant(input logic [1:0] g, input string tag);
    int n;
    exp_t e;
    logic [7:0] a, b;
    n = 0;
    @(negedge clk);
    while (req_ready == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << g));
    a    = req_a[8*g +: 8];
    b    = req_b[8*g +: 8];
    e.id = g;
    e.c  = {1'b0, a} - {1'b0, b};
    q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy !== 1'b0 || q.size() != 0) && n < 30);
    chk({tag, "_drain"}, 32'(n < 30), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic single_op(input logic [1:0] g, input logic [7:0] a, input logic [7:0] b,
                           input string tag);
    req_a[8*g +: 8] = a;
    req_b[8*g +: 8] = b;
    req_valid       = 4'b0001 << g;
    wait_grant(g, tag);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int tg0, tg1, tr;
    logic [8:0] rc;
    logic [1:0] rid;

    rst_n = 1'b0;
    req_valid = 4'b0; req_a = 32'h0; req_b = 32'h0;
    req_valid3 = 4'b0; req_a3 = 32'h0; req_b3 = 32'h0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_sub_en", 32'(sub_en), 32'h0);
    chk("rst_sub_ab", 32'({sub_a, sub_b}), 32'h0);
    chk("rst_rsp", 32'({rsp_valid, rsp_c, rsp_id}), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 10 - 20 on requester 0 with cycle-by-cycle timing
    req_a[7:0] = 8'd10; req_b[7:0] = 8'd20; req_valid = 4'b0001;
    wait_grant(2'd0, "basic");
    chk("basic_T_sub_en", 32'(sub_en), 32'h0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("basic_T1_sub_en", 32'(sub_en), 32'h1);
    chk("basic_T1_ops", 32'({sub_a, sub_b}), 32'h0A14);
    chk("basic_T1_busy", 32'(busy), 32'h1);
    chk("basic_T1_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("basic_T2_sub_en", 32'(sub_en), 32'h1);
    chk("basic_T2_ops", 32'({sub_a, sub_b}), 32'h0A14);
    @(negedge clk);
    chk("basic_T3_pulse", 32'(rsp_valid), 32'h1);
    chk("basic_T3_sub_en", 32'(sub_en), 32'h0);
    chk("basic_T3_ops", 32'({sub_a, sub_b}), 32'h0);
    @(negedge clk);
    chk("basic_T4_nopulse", 32'(rsp_valid), 32'h0);
    chk("basic_T4_hold", 32'(rsp_c), 32'h1F6);
    @(posedge clk); #1;

    single_op(2'd0, 8'd20, 8'd20, "eq");
    single_op(2'd0, 8'd255, 8'd0, "max");
    single_op(2'd0, 8'd0, 8'd255, "neg");

    // ptr becomes 3 after serving requester 2; 0101 must then wrap to 0, then 2
    single_op(2'd2, 8'd100, 8'd1, "set_ptr3");
    req_a = 32'h0033_0044; req_b = 32'h0011_0022;
    req_valid = 4'b0101;
    wait_grant(2'd0, "wrap0");
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_grant(2'd2, "wrap2");
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle("wrap");

    // Reset while the operation for requester 1 is in flight
    req_a[15:8] = 8'd9; req_b[15:8] = 8'd4; req_valid = 4'b0010;
    wait_grant(2'd1, "midrst");
    @(posedge clk); #1;
    req_valid = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sub_en", 32'(sub_en), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ops", 32'({sub_a, sub_b}), 32'h0);
    chk("midrst_rsp_c", 32'(rsp_c), 32'h0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_pulse", 32'(rsp_valid), 32'h0);
    end
    @(posedge clk); #1;

    // All four requesting continuously: strict rotation starting at 0
    req_a = 32'hC8_64_32_0A; req_b = 32'h0F_FF_14_05;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_grant(2'(k), "rr");
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle("rr");

    // Latency-3 instance: pulse and next grant both 5 cycles after the grant
    req_a3 = 32'h0000_0307; req_b3 = 32'h0000_0703;
    req_valid3 = 4'b0011;
    tg0 = -1; tg1 = -1; tr = -1; rc = 9'h0; rid = 2'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready3 != 4'b0000) begin
        if (tg0 < 0) begin
          tg0 = cyc;
          chk("lat3_first_grant", 32'(req_ready3), 32'h1);
        end else if (tg1 < 0) begin
          tg1 = cyc;
          chk("lat3_second_grant", 32'(req_ready3), 32'h2);
        end
      end
      if (rsp_valid3 != 4'b0000 && tr < 0) begin
        tr = cyc; rc = rsp_c3; rid = rsp_id3;
      end
    end
    req_valid3 = 4'b0000;
    chk("lat3_rsp_delay", 32'(tr - tg0), 32'd5);
    chk("lat3_grant_spacing", 32'(tg1 - tg0), 32'd5);
    chk("lat3_rsp_c", 32'(rc), 32'h004);
    chk("lat3_rsp_id", 32'(rid), 32'h0);
    repeat (12) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
